// File: rtl/warp_issue_scheduler_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : warp_issue_scheduler_if
// Brief  : Upstream masks/slots, scoreboard reservation and ALU/LSU dispatch
//          ports of the warp issue scheduler.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
interface warp_issue_scheduler_if #(
  parameter int NUM_WARPS = 32
);
  localparam int c_WARP_W = $clog2(NUM_WARPS);

  logic [NUM_WARPS-1:0]       warp_ready_mask;
  logic [NUM_WARPS-1:0]       ib_valid_mask;
  logic [NUM_WARPS-1:0][62:0] instruction_buffer;
  logic                       sb_tvalid;
  logic [c_WARP_W-1:0]        target_warp;
  logic [4:0]                 target_gpr_out;
  logic [3:0]                 target_unir_out;
  logic                       target_is_pc;
  logic                       target_is_pred;
  logic                       alu_tvalid;
  logic                       alu_tready;
  logic [c_WARP_W+62:0]       alu_tdata;
  logic                       lsu_tvalid;
  logic                       lsu_tready;
  logic [c_WARP_W+62:0]       lsu_tdata;
  logic                       err;

  modport master (
    input  warp_ready_mask, ib_valid_mask, instruction_buffer,
    input  alu_tready, lsu_tready,
    output sb_tvalid, target_warp, target_gpr_out, target_unir_out,
    output target_is_pc, target_is_pred,
    output alu_tvalid, alu_tdata, lsu_tvalid, lsu_tdata, err
  );

  modport slave (
    output warp_ready_mask, ib_valid_mask, instruction_buffer,
    output alu_tready, lsu_tready,
    input  sb_tvalid, target_warp, target_gpr_out, target_unir_out,
    input  target_is_pc, target_is_pred,
    input  alu_tvalid, alu_tdata, lsu_tvalid, lsu_tdata, err
  );
endinterface
`default_nettype wire

// File: rtl/warp_issue_scheduler.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : warp_issue_scheduler
// Brief  : Round-robin single-issue warp scheduler with scoreboard reservation
//          and registered ALU/LSU dispatch. Define KIANA_SCHED_GTO_EN for
//          greedy-then-oldest selection.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
module warp_issue_scheduler #(
  parameter int NUM_WARPS = 32,
  parameter int HOLDOFF   = 2
) (
  input  wire logic              clk,
  input  wire logic              rst,
  warp_issue_scheduler_if.master bus
);
  localparam int c_WARP_W = $clog2(NUM_WARPS);
  localparam int c_HO_W   = $clog2(HOLDOFF + 1);
  localparam int c_DATA_W = c_WARP_W + 63;

  logic [c_HO_W-1:0]   r_holdoff [NUM_WARPS];
  logic [c_WARP_W-1:0] r_last_issued;
  logic                r_sb_tvalid;
  logic [c_WARP_W-1:0] r_target_warp;
  logic [4:0]          r_target_gpr;
  logic [3:0]          r_target_unir;
  logic                r_is_pc;
  logic                r_is_pred;
  logic                r_alu_tvalid;
  logic [c_DATA_W-1:0] r_alu_tdata;
  logic                r_lsu_tvalid;
  logic [c_DATA_W-1:0] r_lsu_tdata;
  logic                r_err;

  logic                w_alu_free;
  logic                w_lsu_free;
  logic [NUM_WARPS-1:0] w_base;
  logic [NUM_WARPS-1:0] w_cand;
  logic                w_found;
  logic [c_WARP_W-1:0] w_sel;
  logic [62:0]         w_slot;
  logic [4:0]          w_rd;
  logic                w_sel_lsu;

  assign w_alu_free = ~r_alu_tvalid | bus.alu_tready;
  assign w_lsu_free = ~r_lsu_tvalid | bus.lsu_tready;

  // Only flags[1:0]==2'b10 goes to the LSU; 00 and 11 both route to the ALU.
  always_comb begin
    w_base = '0;
    w_cand = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      w_base[w] = bus.ib_valid_mask[w] & bus.warp_ready_mask[w] &
                  ((bus.instruction_buffer[w][1:0] == 2'b10) ? w_lsu_free : w_alu_free);
      w_cand[w] = w_base[w] & (r_holdoff[w] == '0);
    end
  end

  always_comb begin
    w_found = 1'b0;
    w_sel   = r_last_issued;
    for (int i = 1; i <= NUM_WARPS; i++) begin
      if (!w_found && w_cand[c_WARP_W'((int'(r_last_issued) + i) % NUM_WARPS)]) begin
        w_found = 1'b1;
        w_sel   = c_WARP_W'((int'(r_last_issued) + i) % NUM_WARPS);
      end
    end
`ifdef KIANA_SCHED_GTO_EN
    if (w_base[r_last_issued]) begin
      w_found = 1'b1;
      w_sel   = r_last_issued;
    end
`endif
  end

  assign w_slot    = bus.instruction_buffer[w_sel];
  assign w_rd      = w_slot[62:58];
  assign w_sel_lsu = (w_slot[1:0] == 2'b10);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int w = 0; w < NUM_WARPS; w++) r_holdoff[w] <= '0;
      r_last_issued <= c_WARP_W'(NUM_WARPS - 1);
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        if (w_found && (w_sel == c_WARP_W'(w)))
          r_holdoff[w] <= c_HO_W'(HOLDOFF);
        else if (r_holdoff[w] != '0)
          r_holdoff[w] <= r_holdoff[w] - c_HO_W'(1);
      end
      if (w_found) r_last_issued <= w_sel;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sb_tvalid   <= 1'b0;
      r_target_warp <= '0;
      r_target_gpr  <= '0;
      r_target_unir <= '0;
      r_is_pc       <= 1'b0;
      r_is_pred     <= 1'b0;
      r_alu_tvalid  <= 1'b0;
      r_alu_tdata   <= '0;
      r_lsu_tvalid  <= 1'b0;
      r_lsu_tdata   <= '0;
      r_err         <= 1'b0;
    end else begin
      r_sb_tvalid <= w_found;
      if (w_found) begin
        r_target_warp <= w_sel;
        r_target_gpr  <= (w_rd[4] == 1'b0)       ? {1'b1, w_rd[3:0]} : 5'd0;
        r_target_unir <= (w_rd[4:3] == 2'b10)    ? {1'b1, w_rd[2:0]} : 4'd0;
        r_is_pc       <= w_slot[2];
        r_is_pred     <= w_slot[4];
        if (w_slot[1:0] == 2'b11) r_err <= 1'b1;
      end
      // A new load wins over an accept in the same cycle.
      if (w_found && !w_sel_lsu) begin
        r_alu_tvalid <= 1'b1;
        r_alu_tdata  <= {w_sel, w_slot};
      end else if (bus.alu_tready) begin
        r_alu_tvalid <= 1'b0;
      end
      if (w_found && w_sel_lsu) begin
        r_lsu_tvalid <= 1'b1;
        r_lsu_tdata  <= {w_sel, w_slot};
      end else if (bus.lsu_tready) begin
        r_lsu_tvalid <= 1'b0;
      end
    end
  end

  assign bus.sb_tvalid       = r_sb_tvalid;
  assign bus.target_warp     = r_target_warp;
  assign bus.target_gpr_out  = r_target_gpr;
  assign bus.target_unir_out = r_target_unir;
  assign bus.target_is_pc    = r_is_pc;
  assign bus.target_is_pred  = r_is_pred;
  assign bus.alu_tvalid      = r_alu_tvalid;
  assign bus.alu_tdata       = r_alu_tdata;
  assign bus.lsu_tvalid      = r_lsu_tvalid;
  assign bus.lsu_tdata       = r_lsu_tdata;
  assign bus.err             = r_err;
endmodule
`default_nettype wire
